// File: rtl/ysyx_bus_pkg.sv
// ysyx_bus_pkg: shared FSM encoding, AXI response codes and LSU access-size strobes
package ysyx_bus_pkg;
    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR, WR_B, DONE} state_t;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [7:0] SZ_B   = 8'h01;
    localparam logic [7:0] SZ_H   = 8'h03;
    localparam logic [7:0] SZ_W   = 8'h0f;
endpackage

// File: rtl/ysyx_lsu_lane_align.sv
// ysyx_lsu_lane_align: moves store data/strobes up to their byte lanes and load data down to bit 0
module ysyx_lsu_lane_align (
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic [31:0] rdata,
    output logic [31:0] wdata_sh,
    output logic [3:0]  wstrb_sh,
    output logic [31:0] rdata_sh
);
    assign wdata_sh = wdata << {off, 3'b000};
    assign wstrb_sh = wstrb << off;
    assign rdata_sh = rdata >> {off, 3'b000};
endmodule

// File: rtl/ysyx_lsu_bus_bridge.sv
// ysyx_lsu_bus_bridge: converts level-held LSU load/store requests into single AXI4-Lite transactions
module ysyx_lsu_bus_bridge
    import ysyx_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    input  logic [7:0]        lsu_rstrb,
    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic              lsu_awvalid,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wstrb,
    input  logic              lsu_wvalid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rvalid,
    output logic              lsu_wready,
    output logic              lsu_err,
    output logic [ADDR_W-1:0] axi_araddr,
    output logic              axi_arvalid,
    input  logic              axi_arready,
    input  logic [DATA_W-1:0] axi_rdata,
    input  logic [1:0]        axi_rresp,
    input  logic              axi_rvalid,
    output logic              axi_rready,
    output logic [ADDR_W-1:0] axi_awaddr,
    output logic              axi_awvalid,
    input  logic              axi_awready,
    output logic [DATA_W-1:0] axi_wdata,
    output logic [3:0]        axi_wstrb,
    output logic              axi_wvalid,
    input  logic              axi_wready,
    input  logic [1:0]        axi_bresp,
    input  logic              axi_bvalid,
    output logic              axi_bready
);
    state_t      state;
    logic [1:0]  addr_q;
    logic        aw_done, w_done, aw_now, w_now;
    logic [1:0]  off;
    logic [31:0] wdata_sh, rdata_sh;
    logic [3:0]  wstrb_sh;
    logic        unused;

    // Load size only matters to the LSU; AXI4-Lite reads always fetch the whole word.
    assign unused = ^{lsu_rstrb, lsu_wstrb[7:4]};
    // In IDLE the shifter aligns the incoming store; afterwards it aligns the returning load.
    assign off    = (state == IDLE) ? lsu_awaddr[1:0] : addr_q;
    assign aw_now = aw_done | (axi_awvalid & axi_awready);
    assign w_now  = w_done | (axi_wvalid & axi_wready);

    ysyx_lsu_lane_align u_align (
        .off      (off),
        .wdata    (lsu_wdata),
        .wstrb    (lsu_wstrb[3:0]),
        .rdata    (axi_rdata),
        .wdata_sh (wdata_sh),
        .wstrb_sh (wstrb_sh),
        .rdata_sh (rdata_sh)
    );

    // Transaction FSM with registered AXI and LSU outputs; completion pulses default low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            lsu_rdata   <= '0;
            lsu_rvalid  <= 1'b0;
            lsu_wready  <= 1'b0;
            lsu_err     <= 1'b0;
            axi_araddr  <= '0;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
            axi_awaddr  <= '0;
            axi_awvalid <= 1'b0;
            axi_wdata   <= '0;
            axi_wstrb   <= '0;
            axi_wvalid  <= 1'b0;
            axi_bready  <= 1'b0;
        end else begin
            lsu_rvalid <= 1'b0;
            lsu_wready <= 1'b0;
            lsu_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (lsu_arvalid) begin
                        addr_q      <= lsu_araddr[1:0];
                        axi_araddr  <= lsu_araddr;
                        axi_arvalid <= 1'b1;
                        state       <= RD_A;
                    end else if (lsu_awvalid && lsu_wvalid) begin
                        addr_q      <= lsu_awaddr[1:0];
                        axi_awaddr  <= lsu_awaddr;
                        axi_wdata   <= wdata_sh;
                        axi_wstrb   <= wstrb_sh;
                        axi_awvalid <= 1'b1;
                        axi_wvalid  <= 1'b1;
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        state       <= WR;
                    end
                end
                RD_A: begin
                    if (axi_arready) begin
                        axi_arvalid <= 1'b0;
                        axi_rready  <= 1'b1;
                        state       <= RD_D;
                    end
                end
                RD_D: begin
                    if (axi_rvalid) begin
                        lsu_rdata  <= rdata_sh;
                        lsu_rvalid <= 1'b1;
                        lsu_err    <= axi_rresp != OKAY;
                        axi_rready <= 1'b0;
                        state      <= DONE;
                    end
                end
                WR: begin
                    if (axi_awvalid && axi_awready) axi_awvalid <= 1'b0;
                    if (axi_wvalid && axi_wready) axi_wvalid <= 1'b0;
                    aw_done <= aw_now;
                    w_done  <= w_now;
                    if (aw_now && w_now) begin
                        axi_bready <= 1'b1;
                        state      <= WR_B;
                    end
                end
                WR_B: begin
                    if (axi_bvalid) begin
                        lsu_wready <= 1'b1;
                        lsu_err    <= axi_bresp != OKAY;
                        axi_bready <= 1'b0;
                        state      <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_lsu_bus_bridge.sv
// tb_ysyx_lsu_bus_bridge: directed vectors plus corner sequences against a small AXI4-Lite slave model
module tb_ysyx_lsu_bus_bridge;
    import ysyx_bus_pkg::*;

    logic        clk = 1'b0, rst = 1'b0;
    logic [31:0] lsu_araddr = '0, lsu_awaddr = '0, lsu_wdata = '0;
    logic        lsu_arvalid = 1'b0, lsu_awvalid = 1'b0, lsu_wvalid = 1'b0;
    logic [7:0]  lsu_rstrb = '0, lsu_wstrb = '0;
    logic [31:0] lsu_rdata, axi_araddr, axi_awaddr, axi_wdata;
    logic        lsu_rvalid, lsu_wready, lsu_err;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp, axi_bresp;
    logic [3:0]  axi_wstrb;

    int          ar_wait = 0, aw_wait = 0, w_wait = 0;
    logic        r_block = 1'b0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = OKAY, s_bresp = OKAY;
    int          ar_c, aw_c, w_c, ar_total;
    logic        aw_got, w_got;
    logic [31:0] ar_seen, aw_seen, w_seen;
    logic [3:0]  strb_seen;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    ysyx_lsu_bus_bridge dut (
        .clk(clk), .rst(rst),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid), .lsu_wready(lsu_wready), .lsu_err(lsu_err),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    // Slave: readies rise after a programmable number of valid cycles; R/B follow one cycle later.
    assign axi_arready = axi_arvalid && (ar_c >= ar_wait);
    assign axi_awready = axi_awvalid && (aw_c >= aw_wait);
    assign axi_wready  = axi_wvalid && (w_c >= w_wait);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ar_c <= 0; aw_c <= 0; w_c <= 0; ar_total <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
            axi_rvalid <= 1'b0; axi_rdata <= '0; axi_rresp <= '0;
            axi_bvalid <= 1'b0; axi_bresp <= '0;
            ar_seen <= '0; aw_seen <= '0; w_seen <= '0; strb_seen <= '0;
        end else begin
            ar_c <= (axi_arvalid && !axi_arready) ? ar_c + 1 : 0;
            aw_c <= (axi_awvalid && !axi_awready) ? aw_c + 1 : 0;
            w_c  <= (axi_wvalid && !axi_wready) ? w_c + 1 : 0;
            if (axi_arvalid && axi_arready) begin
                ar_total <= ar_total + 1;
                ar_seen  <= axi_araddr;
                if (!r_block) begin
                    axi_rvalid <= 1'b1;
                    axi_rdata  <= s_rdata;
                    axi_rresp  <= s_rresp;
                end
            end else if (axi_rvalid && axi_rready) axi_rvalid <= 1'b0;
            if (axi_awvalid && axi_awready) aw_seen <= axi_awaddr;
            if (axi_wvalid && axi_wready) begin
                w_seen    <= axi_wdata;
                strb_seen <= axi_wstrb;
            end
            if ((aw_got || (axi_awvalid && axi_awready)) && (w_got || (axi_wvalid && axi_wready))) begin
                axi_bvalid <= 1'b1;
                axi_bresp  <= s_bresp;
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
            end else begin
                aw_got <= aw_got || (axi_awvalid && axi_awready);
                w_got  <= w_got || (axi_wvalid && axi_wready);
                if (axi_bvalid && axi_bready) axi_bvalid <= 1'b0;
            end
        end
    end

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  strb;
        logic [31:0] s_rdata;
        logic [1:0]  resp;
        int          ar_w, aw_w, w_w, lat;
        logic [31:0] exp_data;
        logic [3:0]  exp_strb;
        logic        exp_err;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctl"}, {24'd0, axi_arvalid, axi_rready, axi_awvalid, axi_wvalid,
                             axi_bready, lsu_rvalid, lsu_wready, lsu_err}, 32'd0);
        chk({name, "_rdata"}, lsu_rdata, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n = 0, viol = 0;
        logic done = 1'b0;
        ar_wait = v.ar_w; aw_wait = v.aw_w; w_wait = v.w_w;
        s_rdata = v.s_rdata; s_rresp = v.resp; s_bresp = v.resp;
        @(negedge clk);
        if (v.rd) begin
            lsu_araddr = v.addr; lsu_rstrb = v.strb; lsu_arvalid = 1'b1;
        end else begin
            lsu_awaddr = v.addr; lsu_wdata = v.wdata; lsu_wstrb = v.strb;
            lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
        end
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (axi_bready && (axi_awvalid || axi_wvalid)) viol++;
            if (lsu_rvalid && lsu_wready) viol++;
            if (lsu_rvalid || lsu_wready) done = 1'b1;
        end
        chk($sformatf("v%0d_done", idx), {31'd0, done}, 32'd1);
        chk($sformatf("v%0d_latency", idx), n, v.lat);
        chk($sformatf("v%0d_kind", idx), {30'd0, lsu_rvalid, lsu_wready}, v.rd ? 32'd2 : 32'd1);
        chk($sformatf("v%0d_err", idx), {31'd0, lsu_err}, {31'd0, v.exp_err});
        chk($sformatf("v%0d_order", idx), viol, 0);
        if (v.rd) begin
            chk($sformatf("v%0d_rdata", idx), lsu_rdata, v.exp_data);
            chk($sformatf("v%0d_araddr", idx), ar_seen, v.addr);
        end else begin
            chk($sformatf("v%0d_wdata", idx), w_seen, v.exp_data);
            chk($sformatf("v%0d_wstrb", idx), {28'd0, strb_seen}, {28'd0, v.exp_strb});
            chk($sformatf("v%0d_awaddr", idx), aw_seen, v.addr);
        end
        @(negedge clk);
        lsu_arvalid = 1'b0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("v%0d_pulse_width", idx), {30'd0, lsu_rvalid, lsu_wready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r_at, w_at, early, pulses, base;
        logic w_err, r_err;
        //          rd    addr           wdata          strb  s_rdata        resp    ar aw w lat exp_data       strb     err
        vt[0]  = '{1'b1, 32'h8000_0010, 32'h0,         SZ_W, 32'hDEADBEEF, OKAY,   0, 0, 0, 3, 32'hDEADBEEF, 4'h0,    1'b0};
        vt[1]  = '{1'b1, 32'h8000_0013, 32'h0,         SZ_B, 32'h12345678, OKAY,   0, 0, 0, 3, 32'h00000012, 4'h0,    1'b0};
        vt[2]  = '{1'b1, 32'h8000_0002, 32'h0,         SZ_H, 32'h12345678, OKAY,   0, 0, 0, 3, 32'h00001234, 4'h0,    1'b0};
        vt[3]  = '{1'b1, 32'h8000_0101, 32'h0,         SZ_B, 32'hA1B2C3D4, OKAY,   2, 0, 0, 5, 32'h00A1B2C3, 4'h0,    1'b0};
        vt[4]  = '{1'b1, 32'h8000_0040, 32'h0,         SZ_W, 32'h0BADCAFE, SLVERR, 0, 0, 0, 3, 32'h0BADCAFE, 4'h0,    1'b1};
        vt[5]  = '{1'b0, 32'h8000_0002, 32'h000000AB,  SZ_B, 32'h0,        OKAY,   0, 0, 0, 3, 32'h00AB0000, 4'b0100, 1'b0};
        vt[6]  = '{1'b0, 32'h8000_0001, 32'h0000BEEF,  SZ_H, 32'h0,        OKAY,   0, 0, 0, 3, 32'h00BEEF00, 4'b0110, 1'b0};
        vt[7]  = '{1'b0, 32'h8000_0004, 32'hCAFEF00D,  SZ_W, 32'h0,        OKAY,   0, 0, 0, 3, 32'hCAFEF00D, 4'b1111, 1'b0};
        vt[8]  = '{1'b0, 32'h8000_0007, 32'h00001234,  SZ_H, 32'h0,        OKAY,   0, 0, 0, 3, 32'h34000000, 4'b1000, 1'b0};
        vt[9]  = '{1'b0, 32'h8000_0009, 32'h112233CD,  SZ_B, 32'h0,        OKAY,   0, 2, 0, 5, 32'h2233CD00, 4'b0010, 1'b0};
        vt[10] = '{1'b0, 32'h8000_0020, 32'h55667788,  SZ_W, 32'h0,        OKAY,   0, 0, 3, 6, 32'h55667788, 4'b1111, 1'b0};
        vt[11] = '{1'b0, 32'h8000_0030, 32'h00000001,  SZ_W, 32'h0,        SLVERR, 0, 0, 0, 3, 32'h00000001, 4'b1111, 1'b1};

        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vt[i], i);

        // Level-held arvalid: one AR per request, the second only after IDLE re-entry.
        ar_wait = 0; s_rdata = 32'h01020304; s_rresp = OKAY;
        base = ar_total; pulses = 0;
        @(negedge clk);
        lsu_araddr = 32'h8000_0050; lsu_rstrb = SZ_W; lsu_arvalid = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (lsu_rvalid) pulses++;
            if (c == 3) chk("hold_first_rvalid", {31'd0, lsu_rvalid}, 32'd1);
            if (c == 4) chk("hold_done_no_ar", {31'd0, axi_arvalid}, 32'd0);
            if (c == 5) chk("hold_second_ar", {31'd0, axi_arvalid}, 32'd1);
        end
        chk("hold_rvalid_pulses", pulses, 2);
        chk("hold_ar_count", ar_total - base, 2);
        @(negedge clk) lsu_arvalid = 1'b0;
        repeat (2) @(posedge clk);

        // Simultaneous load and store: read first, write afterwards with SLVERR.
        s_rdata = 32'h55AA33CC; s_rresp = OKAY; s_bresp = SLVERR;
        r_at = 0; w_at = 0; early = 0; w_err = 1'b0; r_err = 1'b1;
        @(negedge clk);
        lsu_araddr = 32'h8000_0060; lsu_rstrb = SZ_W; lsu_arvalid = 1'b1;
        lsu_awaddr = 32'h8000_0008; lsu_wdata = 32'h0BADF00D; lsu_wstrb = SZ_W;
        lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (axi_awvalid && r_at == 0) early++;
            if (lsu_rvalid) begin
                r_at = c; r_err = lsu_err; lsu_arvalid = 1'b0;
            end
            if (lsu_wready) begin
                w_at = c; w_err = lsu_err; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
            end
        end
        chk("both_read_cycle", r_at, 3);
        chk("both_read_err", {31'd0, r_err}, 32'd0);
        chk("both_read_data", lsu_rdata, 32'h55AA33CC);
        chk("both_write_cycle", w_at, 7);
        chk("both_write_err", {31'd0, w_err}, 32'd1);
        chk("both_no_early_aw", early, 0);
        chk("both_wdata", w_seen, 32'h0BADF00D);
        s_bresp = OKAY;

        // Asynchronous reset while waiting for R data, then a normal load.
        r_block = 1'b1;
        @(negedge clk);
        lsu_araddr = 32'h8000_0070; lsu_rstrb = SZ_W; lsu_arvalid = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("rst_in_rd_d_rready", {31'd0, axi_rready}, 32'd1);
        #2 rst = 1'b0;
        #1 chk_zero("async_reset");
        lsu_arvalid = 1'b0; r_block = 1'b0;
        @(negedge clk) rst = 1'b1;
        run_vec(vt[0], 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
